conv2_window_buffer: RTL and testbench
======================================

# conv2_window_buffer

Streaming sliding-window buffer placed directly upstream of `convlayer2`. It accepts one 4-channel int8 sample per handshake from the layer-1 output stream. It assembles 5-tap windows per channel and presents them as the `in1..in4` operands of `convlayer2`, together with the enable that drives `convlayer2`'s `en`. The block handles frame boundaries, stride, and back-pressure.

## Interface
Parameters:
- `NCH`, 4: input channels. Fixed by `convlayer2`.
- `TAPS`, 5: window length.
- `DW`, 8: sample width, signed.
- `FRAME_LEN`, 64: samples per frame. Must be ≥ `TAPS`.
- `STRIDE`, 1: window stride. `(FRAME_LEN-TAPS) % STRIDE == 0` is checked at elaboration.

Ports:
- `clk` in 1: the block's single clock.
- `rst` in 1: asynchronous, active-high reset.
- `s_valid` in 1: input sample valid.
- `s_ready` out 1: block accepts a sample.
- `s_data` in `[NCH-1:0][DW-1:0]`: one signed sample per channel.
- `s_last` in 1: marks the final sample of a frame.
- `m_valid` out 1: window valid.
- `m_ready` in 1: consumer accepts the window.
- `win1..win4` out `[TAPS-1:0][DW-1:0]`: per-channel window. `[0]` is the oldest sample, `[TAPS-1]` the newest.
- `m_last` out 1: the window is the last one of the frame.
- `conv_en` out 1: `m_valid & m_ready`. Drives `convlayer2.en`.
- `err_frame` out 1: sticky frame-length mismatch flag.

## Operation
- A sample is accepted when `s_valid & s_ready`.
- Each channel keeps a `TAPS`-deep shift register. On accept, a new sample enters at `[TAPS-1]` and the oldest is dropped.
- FSM states:
  - FILL: counts accepted samples with `fill_cnt`, 0..`TAPS-1`. When the `TAPS`-th sample of the frame is accepted, the block loads the output window, sets `m_valid`, clears `phase`, and moves to RUN.
  - RUN: each accepted sample increments `phase` mod `STRIDE`. A window is emitted when the post-increment `phase` is 0.
- `samp_cnt` counts accepted samples in the frame, 0..`FRAME_LEN-1`.
- The last sample of a frame is the accepted sample with `samp_cnt == FRAME_LEN-1`. On it:
  - the window is emitted with `m_last=1`;
  - `samp_cnt`, `fill_cnt` and `phase` are cleared and the FSM returns to FILL;
  - the shift registers are not cleared, but the next frame's first window contains only new-frame samples.
- Frame mismatch: if `s_last` disagrees with `samp_cnt == FRAME_LEN-1` on an accepted sample, `err_frame` is set until reset. Framing always follows the internal counter.
- Output register: `win*` and `m_last` hold while `m_valid & !m_ready`.
- Simultaneous events: an accept that produces a window and a consume (`m_ready`) in the same cycle both occur. The new window replaces the old one and `m_valid` stays 1.
- Arithmetic: no arithmetic on sample data. Samples are passed bit-exact as two's-complement int8.

## Timing
- `s_ready = !m_valid | m_ready`. This is combinational, with no registered skid.
- Window latency: `m_valid` rises on the clock edge that accepts the completing sample, i.e. the window is visible one cycle after `s_data` is presented.
- `m_valid` falls after an edge with `m_ready=1` and no new window.
- Throughput: one window per cycle when `STRIDE=1`, `s_valid=1` and `m_ready=1`.
- Reset, asynchronous, applies to all state regardless of phase:
  - `m_valid`, `m_last`, `err_frame` = 0;
  - `win*` = 0, shift registers = 0;
  - FSM = FILL, counters = 0.
  - `s_ready` = 1 after reset.
  - Reset mid-frame discards the partial frame. The next accepted sample is sample 0.
- Windows per frame = `(FRAME_LEN-TAPS)/STRIDE + 1`.

## Structure
- Shared package `cnn_pkg` defines:
  - `DW`, `TAPS`, `NCH`;
  - `typedef logic signed [DW-1:0] sample_t`;
  - `typedef sample_t [TAPS-1:0] window_t`;
  - the FSM enum `win_state_e {FILL, RUN}`.
- Sub-module `tap_shift_reg`: one channel's `TAPS`-deep shift register with a shift enable. It is instantiated `NCH` times. The FSM, counters and output register live in the top level.

## Test plan
- FRAME_LEN=8, STRIDE=1, ch1 samples 1..8, ch2 = −1..−8, continuous valid/ready. Required response:
  - 4 windows;
  - first window `win1={1,2,3,4,5}` (`[0]`=1), `win2={-1,-2,-3,-4,-5}`;
  - last window `win1={4,5,6,7,8}` with `m_last=1`;
  - `conv_en` high exactly 4 cycles.
- FRAME_LEN=9, STRIDE=2, samples 1..9. Required: 3 windows with newest samples 5, 7, 9; `m_last` only on `{5..9}`.
- Back-pressure: hold `m_ready=0` for 3 cycles after the first window. Required:
  - `s_ready=0`;
  - `win1` stays `{1..5}`;
  - no sample lost; the next window is `{2..6}`.
- Two back-to-back frames, ch1 values 1..8 then 11..18. Required: the second frame's first window is `{11..15}`, with no mixing of values from the first frame.
- `s_last` asserted on sample index 5 of an 8-sample frame. Required: `err_frame=1` from the next cycle; windowing continues per `FRAME_LEN`.
- Assert `rst` for 1 cycle after 3 samples. Required:
  - `m_valid=0` immediately, asynchronously;
  - the next 5 samples 20..24 yield `win1={20,21,22,23,24}`.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared CNN datapath types: sample/window shapes and the window-buffer FSM states.
package cnn_pkg;

  localparam int DW   = 8;
  localparam int TAPS = 5;
  localparam int NCH  = 4;

  typedef logic signed [DW-1:0] sample_t;
  typedef sample_t [TAPS-1:0]   window_t;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } win_state_e;

endpackage

// File: rtl/conv2_window_buffer_if.sv
// Sample stream in, window stream out, plus the convlayer2 enable and the framing error flag.
interface conv2_window_buffer_if;
  import cnn_pkg::*;

  logic                     s_valid;
  logic                     s_ready;
  logic [NCH-1:0][DW-1:0]   s_data;
  logic                     s_last;
  logic                     m_valid;
  logic                     m_ready;
  window_t                  win1;
  window_t                  win2;
  window_t                  win3;
  window_t                  win4;
  logic                     m_last;
  logic                     conv_en;
  logic                     err_frame;

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, win1, win2, win3, win4, m_last, conv_en, err_frame
  );

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, win1, win2, win3, win4, m_last, conv_en, err_frame
  );

endinterface

// File: rtl/conv2_window_buffer_tap_shift_reg.sv
// One channel's TAPS-deep history; [0] oldest, [TAPS-1] newest. Exposes the post-shift view.
module tap_shift_reg
  import cnn_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    shift_en,
  input  sample_t din,
  output window_t shifted
);

  window_t sr_q;
  window_t sr_d;

  always_comb begin
    sr_d = sr_q;
    if (shift_en) begin
      sr_d = {din, sr_q[TAPS-1:1]};
    end else begin
      sr_d = sr_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  // The top loads its output window from the value the register is about to take.
  assign shifted = sr_d;

endmodule

// File: rtl/conv2_window_buffer.sv
// Sliding-window buffer feeding convlayer2: fills TAPS samples per frame, then emits every STRIDE samples.
module conv2_window_buffer
#(
  parameter int NCH       = cnn_pkg::NCH,
  parameter int TAPS      = cnn_pkg::TAPS,
  parameter int DW        = cnn_pkg::DW,
  parameter int FRAME_LEN = 64,
  parameter int STRIDE    = 1
)(
  input  logic                  clk,
  input  logic                  rst,
  conv2_window_buffer_if.slave  bus
);
  import cnn_pkg::sample_t;
  import cnn_pkg::window_t;
  import cnn_pkg::win_state_e;
  import cnn_pkg::FILL;
  import cnn_pkg::RUN;

  if (NCH != cnn_pkg::NCH || TAPS != cnn_pkg::TAPS || DW != cnn_pkg::DW || FRAME_LEN < TAPS ||
      STRIDE < 1 || ((FRAME_LEN - TAPS) % STRIDE) != 0) begin : g_bad_cfg
    $error("conv2_window_buffer: illegal NCH/TAPS/DW/FRAME_LEN/STRIDE combination");
  end

  localparam int SCW = $clog2(FRAME_LEN);
  localparam int FCW = $clog2(TAPS);
  localparam int PW  = (STRIDE > 1) ? $clog2(STRIDE) : 1;

  win_state_e           state_q, state_d;
  logic [FCW-1:0]       fill_cnt_q, fill_cnt_d;
  logic [PW-1:0]        phase_q, phase_d;
  logic [SCW-1:0]       samp_cnt_q, samp_cnt_d;
  window_t [NCH-1:0]    win_q, win_d;
  logic                 m_valid_q, m_valid_d;
  logic                 m_last_q, m_last_d;
  logic                 err_q, err_d;

  window_t [NCH-1:0]    shifted_s;
  logic                 accept_s;
  logic                 emit_s;
  logic                 frame_end_s;
  logic [PW-1:0]        phase_inc_s;

  assign bus.s_ready = !m_valid_q | bus.m_ready;
  assign accept_s    = bus.s_valid & bus.s_ready;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    tap_shift_reg u_sr (
      .clk      (clk),
      .rst      (rst),
      .shift_en (accept_s),
      .din      (sample_t'(bus.s_data[c])),
      .shifted  (shifted_s[c])
    );
  end

  always_comb begin
    state_d     = state_q;
    fill_cnt_d  = fill_cnt_q;
    phase_d     = phase_q;
    samp_cnt_d  = samp_cnt_q;
    win_d       = win_q;
    m_valid_d   = m_valid_q;
    m_last_d    = m_last_q;
    err_d       = err_q;
    emit_s      = 1'b0;
    frame_end_s = (samp_cnt_q == SCW'(FRAME_LEN - 1));
    phase_inc_s = (phase_q == PW'(STRIDE - 1)) ? '0 : phase_q + 1'b1;

    if (accept_s) begin
      if (bus.s_last != frame_end_s) begin
        err_d = 1'b1;
      end else begin
        err_d = err_q;
      end

      case (state_q)
        FILL: begin
          if (fill_cnt_q == FCW'(TAPS - 1)) begin
            emit_s     = 1'b1;
            phase_d    = '0;
            fill_cnt_d = '0;
            state_d    = RUN;
          end else begin
            fill_cnt_d = fill_cnt_q + 1'b1;
          end
        end
        RUN: begin
          phase_d = phase_inc_s;
          emit_s  = (phase_inc_s == '0);
        end
        default: state_d = FILL;
      endcase

      // Framing is driven purely by the sample counter; s_last only feeds the error flag.
      if (frame_end_s) begin
        samp_cnt_d = '0;
        fill_cnt_d = '0;
        phase_d    = '0;
        state_d    = FILL;
      end else begin
        samp_cnt_d = samp_cnt_q + 1'b1;
      end
    end else begin
      emit_s = 1'b0;
    end

    if (emit_s) begin
      win_d     = shifted_s;
      m_valid_d = 1'b1;
      m_last_d  = frame_end_s;
    end else if (bus.m_ready) begin
      m_valid_d = 1'b0;
    end else begin
      m_valid_d = m_valid_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FILL;
      fill_cnt_q <= '0;
      phase_q    <= '0;
      samp_cnt_q <= '0;
      win_q      <= '0;
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
      phase_q    <= phase_d;
      samp_cnt_q <= samp_cnt_d;
      win_q      <= win_d;
      m_valid_q  <= m_valid_d;
      m_last_q   <= m_last_d;
      err_q      <= err_d;
    end
  end

  assign bus.m_valid   = m_valid_q;
  assign bus.win1      = win_q[0];
  assign bus.win2      = win_q[1];
  assign bus.win3      = win_q[2];
  assign bus.win4      = win_q[3];
  assign bus.m_last    = m_last_q;
  assign bus.conv_en   = m_valid_q & bus.m_ready;
  assign bus.err_frame = err_q;

endmodule

// File: tb/tb_conv2_window_buffer.sv
// Scoreboard bench: two buffers (FRAME_LEN=8/STRIDE=1 and FRAME_LEN=9/STRIDE=2) driven from directed vectors.
module tb_conv2_window_buffer;
  import cnn_pkg::*;

  typedef struct {
    window_t w1;
    window_t w2;
    logic    last;
  } exp_t;

  typedef struct {
    string  nm;
    longint act;
    longint exp;
  } req_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel = 1'b0;
  logic tv_valid = 1'b0;
  logic tv_last = 1'b0;
  logic tv_ready = 1'b1;
  logic [NCH-1:0][DW-1:0] tv_data = '0;
  logic rdy_mux;

  exp_t exp_a[$];
  exp_t exp_b[$];
  req_t dir_q[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   conv_cnt = 0;

  always #5 clk = ~clk;

  conv2_window_buffer_if a_if ();
  conv2_window_buffer_if b_if ();

  assign a_if.s_valid = tv_valid & (sel == 1'b0);
  assign a_if.s_data  = tv_data;
  assign a_if.s_last  = tv_last;
  assign a_if.m_ready = tv_ready;
  assign b_if.s_valid = tv_valid & (sel == 1'b1);
  assign b_if.s_data  = tv_data;
  assign b_if.s_last  = tv_last;
  assign b_if.m_ready = tv_ready;
  assign rdy_mux      = sel ? b_if.s_ready : a_if.s_ready;

  conv2_window_buffer #(.FRAME_LEN(8), .STRIDE(1)) u_a (.clk(clk), .rst(rst), .bus(a_if.slave));
  conv2_window_buffer #(.FRAME_LEN(9), .STRIDE(2)) u_b (.clk(clk), .rst(rst), .bus(b_if.slave));

  function automatic window_t mkwin(input int first);
    window_t w;
    for (int i = 0; i < TAPS; i++) w[i] = sample_t'(first + i);
    return w;
  endfunction

  function automatic window_t negw(input window_t x);
    window_t w;
    for (int i = 0; i < TAPS; i++) w[i] = sample_t'(-x[i]);
    return w;
  endfunction

  task automatic post(input string nm, input longint act, input longint exp);
    req_t r;
    r.nm = nm; r.act = act; r.exp = exp;
    dir_q.push_back(r);
  endtask

  task automatic push_exp(input logic which, input int first, input logic last);
    exp_t e;
    e.w1 = mkwin(first);
    e.w2 = negw(e.w1);
    e.last = last;
    if (which) exp_b.push_back(e);
    else exp_a.push_back(e);
  endtask

  // Monitor: evaluates posted direct checks and pops expected windows on every handshake.
  always @(negedge clk) begin
    exp_t e;
    req_t r;
    while (dir_q.size() > 0) begin
      r = dir_q.pop_front();
      total_cnt++;
      if (r.act == r.exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", r.nm, r.act, r.exp);
    end
    if (a_if.conv_en) conv_cnt++;
    if (a_if.m_valid && a_if.m_ready) begin
      total_cnt++;
      if (exp_a.size() == 0) begin
        $display("FAIL a_unexpected_win: got win1 0x%0h expected no window", a_if.win1);
      end else begin
        e = exp_a.pop_front();
        if (a_if.win1 == e.w1 && a_if.win2 == e.w2 && a_if.m_last == e.last) pass_cnt++;
        else $display("FAIL a_win: got win1 0x%0h win2 0x%0h last %0b expected win1 0x%0h win2 0x%0h last %0b",
                      a_if.win1, a_if.win2, a_if.m_last, e.w1, e.w2, e.last);
      end
    end
    if (b_if.m_valid && b_if.m_ready) begin
      total_cnt++;
      if (exp_b.size() == 0) begin
        $display("FAIL b_unexpected_win: got win1 0x%0h expected no window", b_if.win1);
      end else begin
        e = exp_b.pop_front();
        if (b_if.win1 == e.w1 && b_if.win2 == e.w2 && b_if.m_last == e.last) pass_cnt++;
        else $display("FAIL b_win: got win1 0x%0h win2 0x%0h last %0b expected win1 0x%0h win2 0x%0h last %0b",
                      b_if.win1, b_if.win2, b_if.m_last, e.w1, e.w2, e.last);
      end
    end
  end

  task automatic send(input int v, input logic last);
    int  n;
    bit  done;
    tv_valid   = 1'b1;
    tv_last    = last;
    tv_data[0] = DW'(v);
    tv_data[1] = DW'(-v);
    tv_data[2] = DW'(v + 64);
    tv_data[3] = DW'(~v);
    n = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (rdy_mux) begin
        @(posedge clk); #1;
        done = 1'b1;
      end else begin
        n++;
        if (n >= 50) begin
          post("send_timeout", 64'd1, 64'd0);
          done = 1'b1;
        end
      end
    end
  endtask

  task automatic send_frame(input int first, input int len, input int bad_idx);
    for (int i = 0; i < len; i++) send(first + i, (i == len - 1) || (i == bad_idx));
  endtask

  task automatic idle();
    tv_valid = 1'b0;
    tv_last  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_a.size() != 0 || exp_b.size() != 0) && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= 100) post("drain_timeout", 64'd1, 64'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    int n;
    repeat (2) @(posedge clk);
    #1;
    post("rst_m_valid", a_if.m_valid, 0);
    post("rst_s_ready", a_if.s_ready, 1);
    post("rst_err", a_if.err_frame, 0);
    post("rst_win1", a_if.win1, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Frame of 8, stride 1: four windows, conv_en high four cycles.
    sel = 1'b0;
    for (int k = 1; k <= 4; k++) push_exp(1'b0, k, k == 4);
    base = conv_cnt;
    send_frame(1, 8, -1);
    idle();
    drain();
    post("conv_en_cycles", conv_cnt - base, 4);

    // Frame of 9, stride 2: newest samples 5, 7, 9.
    sel = 1'b1;
    push_exp(1'b1, 1, 1'b0);
    push_exp(1'b1, 3, 1'b0);
    push_exp(1'b1, 5, 1'b1);
    send_frame(1, 9, -1);
    idle();
    drain();

    // Back-pressure for three cycles after the first window.
    sel = 1'b0;
    for (int k = 1; k <= 4; k++) push_exp(1'b0, k, k == 4);
    tv_ready = 1'b0;
    for (int i = 1; i <= 5; i++) send(i, 1'b0);
    tv_valid = 1'b1;
    tv_data[0] = DW'(6);
    repeat (3) begin
      @(negedge clk);
      post("bp_s_ready", a_if.s_ready, 0);
      post("bp_m_valid", a_if.m_valid, 1);
      post("bp_win1_hold", a_if.win1, mkwin(1));
    end
    @(posedge clk); #1;
    tv_ready = 1'b1;
    send(6, 1'b0);
    send(7, 1'b0);
    send(8, 1'b1);
    idle();
    drain();

    // Back-to-back frames must not mix.
    for (int k = 1; k <= 4; k++) push_exp(1'b0, k, k == 4);
    for (int k = 11; k <= 14; k++) push_exp(1'b0, k, k == 14);
    send_frame(1, 8, -1);
    send_frame(11, 8, -1);
    idle();
    drain();

    // Early s_last on index 5: sticky error, windowing unchanged.
    post("err_before", a_if.err_frame, 0);
    for (int k = 1; k <= 4; k++) push_exp(1'b0, k, k == 4);
    for (int i = 0; i < 8; i++) begin
      send(1 + i, (i == 5) || (i == 7));
      if (i == 5) post("err_after_bad_last", a_if.err_frame, 1);
    end
    idle();
    drain();
    post("err_sticky", a_if.err_frame, 1);

    // Asynchronous reset with a window pending.
    tv_ready = 1'b0;
    for (int i = 1; i <= 5; i++) send(i, 1'b0);
    idle();
    @(negedge clk);
    post("pre_rst_m_valid", a_if.m_valid, 1);
    #2 rst = 1'b1;
    #1;
    post("async_rst_m_valid", a_if.m_valid, 0);
    post("async_rst_s_ready", a_if.s_ready, 1);
    post("async_rst_err", a_if.err_frame, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    tv_ready = 1'b1;

    // Reset after three samples discards the partial frame.
    for (int i = 7; i <= 9; i++) send(i, 1'b0);
    idle();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    post("rst_mid_m_valid", a_if.m_valid, 0);
    push_exp(1'b0, 20, 1'b0);
    for (int i = 20; i <= 24; i++) send(i, 1'b0);
    idle();
    drain();

    post("exp_a_empty", exp_a.size(), 0);
    post("exp_b_empty", exp_b.size(), 0);
    n = 0;
    while (dir_q.size() != 0 && n < 10) begin
      @(negedge clk); #1;
      n++;
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
